// File: rtl/aes_link_pkg.sv
// Shared types and helpers for the AES UART link peer.
// Covers the FSM state encoding and the regenerated test-pattern byte.
package aes_link_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TX_LOAD   = 3'd1,
    TX_WAIT   = 3'd2,
    RX_CIPHER = 3'd3,
    RX_PLAIN  = 3'd4,
    FINISH    = 3'd5
  } link_state_e;

  // Image byte i is the low byte of its index XORed with a fixed mask.
  function automatic uart_byte_t pattern_byte(input uart_byte_t idx, input uart_byte_t pat_xor);
    return idx ^ pat_xor;
  endfunction

endpackage

// File: rtl/link_gap_timer.sv
// Idle-gap watchdog for the receive phase: counts enabled clocks since the
// last clear and strobes when the count sits at TIMEOUT_CYCLES-1.
module link_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != TERM)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A clear in the terminal cycle wins: the byte that arrived restarts the gap.
  assign expired_o = enable_i && !clear_i && (count_q == TERM);

endmodule

// File: rtl/aes_uart_link_peer.sv
// Board-side peer of the AES UART loop: transmits the pattern image, then
// collects ciphertext and recovered plaintext and reports pass/error status.
module aes_uart_link_peer
  import aes_link_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 64,
  parameter uart_byte_t  PAT_XOR        = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  localparam int unsigned CW = $clog2(NUM_BYTES + 1),
  localparam int unsigned IW = $clog2(NUM_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_done,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [CW-1:0] err_count,
  output logic [IW-1:0] first_err_idx,
  output logic [7:0]    cipher_xor,
  output logic          cipher_passthru
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);
  localparam logic [CW-1:0] ERR_MAX  = '1;

  link_state_e   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  uart_byte_t    tx_data_q, tx_data_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] err_q, err_d;
  logic [IW-1:0] first_err_q, first_err_d;
  uart_byte_t    cxor_q, cxor_d;
  logic          passthru_q, passthru_d;

  logic          rx_phase;
  logic          gap_clear;
  logic          gap_expired;
  logic          last_idx;
  logic [IW-1:0] idx_inc;
  uart_byte_t    exp_byte;

  assign rx_phase = (state_q == RX_CIPHER) || (state_q == RX_PLAIN);
  assign last_idx = (idx_q == LAST_IDX);
  assign idx_inc  = idx_q + IW'(1);
  assign exp_byte = pattern_byte(UART_BYTE_W'(idx_q), PAT_XOR);

  // Gap restarts on entry to the ciphertext phase and on every accepted byte.
  assign gap_clear = ((state_q == TX_WAIT) && tx_done && last_idx) || (rx_phase && rx_done);

  link_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (gap_clear),
    .enable_i (rx_phase),
    .expired_o(gap_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tx_data_q   <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= '0;
      first_err_q <= '0;
      cxor_q      <= '0;
      passthru_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      cxor_q      <= cxor_d;
      passthru_q  <= passthru_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    cxor_d      = cxor_q;
    passthru_d  = passthru_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          err_d       = '0;
          first_err_d = '0;
          cxor_d      = '0;
          passthru_d  = 1'b1;
          idx_d       = '0;
          tx_data_d   = pattern_byte('0, PAT_XOR);
          state_d     = TX_LOAD;
        end
      end

      TX_LOAD: state_d = TX_WAIT;

      TX_WAIT: begin
        if (tx_done) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = RX_CIPHER;
          end else begin
            idx_d     = idx_inc;
            tx_data_d = pattern_byte(UART_BYTE_W'(idx_inc), PAT_XOR);
            state_d   = TX_LOAD;
          end
        end
      end

      RX_CIPHER: begin
        if (rx_done) begin
          cxor_d = cxor_q ^ rx_data;
          if (rx_data != exp_byte) begin
            passthru_d = 1'b0;
          end
          if (last_idx) begin
            idx_d   = '0;
            state_d = RX_PLAIN;
          end else begin
            idx_d = idx_inc;
          end
        end else if (gap_expired) begin
          timeout_d = 1'b1;
          state_d   = FINISH;
        end
      end

      RX_PLAIN: begin
        if (rx_done) begin
          if (rx_data != exp_byte) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + CW'(1);
            end
            if (err_q == '0) begin
              first_err_d = idx_q;
            end
          end
          if (last_idx) begin
            state_d = FINISH;
          end else begin
            idx_d = idx_inc;
          end
        end else if (gap_expired) begin
          timeout_d = 1'b1;
          state_d   = FINISH;
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Verdict is latched on entry to FINISH so it is valid alongside done.
    if ((state_d == FINISH) && (state_q != FINISH)) begin
      pass_d = (err_d == '0) && !timeout_d;
    end
  end

  always_comb begin
    tx_start = (state_q == TX_LOAD);
    done     = (state_q == FINISH);
    busy     = (state_q == TX_LOAD) || (state_q == TX_WAIT) || rx_phase;
  end

  assign tx_data         = tx_data_q;
  assign pass            = pass_q;
  assign timeout         = timeout_q;
  assign err_count       = err_q;
  assign first_err_idx   = first_err_q;
  assign cipher_xor      = cxor_q;
  assign cipher_passthru = passthru_q;

endmodule

// File: tb/tb_aes_uart_link_peer.sv
// Directed bench for aes_uart_link_peer: a 16-byte image, a hand-driven
// UART TX/RX model and hand-computed expected results.
module tb_aes_uart_link_peer;

  localparam int NB  = 16;
  localparam int TMO = 100;
  localparam int CW  = $clog2(NB + 1);
  localparam int IW  = $clog2(NB);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_done;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [CW-1:0] err_count;
  logic [IW-1:0] first_err_idx;
  logic [7:0]    cipher_xor;
  logic          cipher_passthru;

  aes_uart_link_peer #(
    .NUM_BYTES     (NB),
    .PAT_XOR       (8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .tx_done        (tx_done),
    .rx_data        (rx_data),
    .rx_done        (rx_done),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_idx  (first_err_idx),
    .cipher_xor     (cipher_xor),
    .cipher_passthru(cipher_passthru)
  );

  always #5 clk = ~clk;

  // Pattern i ^ A5, written out by hand.
  logic [7:0] exp_pat [NB] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2,
                               8'hAD, 8'hAC, 8'hAF, 8'hAE, 8'hA9, 8'hA8, 8'hAB, 8'hAA};
  // Stand-in ciphertext; its XOR is FF^FF^FF^FE = 8'h01.
  logic [7:0] ctr_ct  [NB] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                               8'h11, 8'h22, 8'h44, 8'h88, 8'hF0, 8'h0F, 8'h3C, 8'hC2};
  logic [7:0] cipher_tab [NB];
  logic [7:0] plain_tab  [NB];

  int unsigned cyc = 0;
  int unsigned tx_start_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned last_rx_cyc = 0;
  int unsigned done_cyc = 0;
  int n_vec = 0;
  int n_miscmp = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) tx_start_cnt <= tx_start_cnt + 1;
    if (done)     done_cnt     <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete exchange. Entered and left on a falling edge.
  task automatic run_link(input int n_rx, input bit noise, input int abort_at);
    int k;
    int unsigned c0;
    int unsigned d0;
    c0 = tx_start_cnt;
    d0 = done_cnt;
    if (noise) begin
      rx_data = 8'h00; rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      @(negedge clk);
      check("idle_rx_ignored_busy", busy, 0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_tx_start_latency", tx_start, 1);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < NB; i++) begin
      k = 0;
      while (!tx_start && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("tx_start_seen", tx_start, 1);
      check("tx_data", tx_data, exp_pat[i]);
      if (i == abort_at) begin
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_tx_start", tx_start, 0);
        check("abort_tx_data", tx_data, 0);
        check("abort_passthru", cipher_passthru, 0);
        check("abort_done", done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        return;
      end
      @(negedge clk);
      if (noise) begin
        rx_data = 8'h5A; rx_done = 1'b1; start = i[0];
      end
      @(negedge clk);
      rx_done = 1'b0; start = 1'b0;
      @(negedge clk);
      if (i == 0) check("tx_data_held", tx_data, exp_pat[0]);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    check("tx_start_pulses", tx_start_cnt - c0, NB);
    for (int j = 0; j < n_rx; j++) begin
      if (noise && (j % 5 == 0)) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rx_data = (j < NB) ? cipher_tab[j] : plain_tab[j - NB];
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      last_rx_cyc = cyc;
    end
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1);
    done_cyc = cyc;
    if (noise) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("one_done_pulse", done_cnt - d0, 1);
  endtask

  task automatic check_results(input string tag, input logic exp_pass, input int exp_err,
                               input int exp_first, input logic [7:0] exp_xor,
                               input logic exp_thru, input logic exp_tmo);
    check({tag, ".pass"}, pass, exp_pass);
    check({tag, ".err_count"}, err_count, exp_err);
    check({tag, ".first_err_idx"}, first_err_idx, exp_first);
    check({tag, ".cipher_xor"}, cipher_xor, exp_xor);
    check({tag, ".passthru"}, cipher_passthru, exp_thru);
    check({tag, ".timeout"}, timeout, exp_tmo);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; tx_done = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_done", done, 0);
    check_results("rst", 0, 0, 0, 8'h00, 0, 0);
    reset = 1'b0;
    @(negedge clk);

    // Normal CTR-style exchange, exact plaintext back.
    cipher_tab = ctr_ct;
    plain_tab  = exp_pat;
    run_link(2 * NB, 0, -1);
    check_results("s1", 1, 0, 0, 8'h01, 0, 0);

    // Two corrupted plaintext bytes.
    plain_tab[5] = 8'h00;
    plain_tab[9] = 8'h53;
    run_link(2 * NB, 0, -1);
    check_results("s2", 0, 2, 5, 8'h01, 0, 0);

    // AES bypassed: ciphertext equals pattern.
    cipher_tab = exp_pat;
    plain_tab  = exp_pat;
    run_link(2 * NB, 0, -1);
    check_results("s3", 1, 0, 0, 8'h00, 1, 0);

    // Reset while waiting on byte 7, then a clean restart from byte 0.
    cipher_tab = ctr_ct;
    run_link(2 * NB, 0, 7);
    check_results("s5_abort", 0, 0, 0, 8'h00, 0, 0);
    run_link(2 * NB, 0, -1);
    check_results("s5_rerun", 1, 0, 0, 8'h01, 0, 0);

    // Stray rx_done and start pulses must not disturb the run.
    run_link(2 * NB, 1, -1);
    check_results("s6", 1, 0, 0, 8'h01, 0, 0);

    // Sender stops after 20 of 32 bytes.
    run_link(20, 0, -1);
    check("s4.gap_to_done", done_cyc - last_rx_cyc, TMO);
    check_results("s4", 0, 0, 0, 8'h01, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
